// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// single-bubble load-use interlock. Feeds the ALU operands directly.
module id_ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [RA_W-1:0] id_rs1_addr,
    input  logic [RA_W-1:0] id_rs2_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [3:0]      id_alu_op,
    input  logic            id_src1_pc,
    input  logic            id_src2_imm,
    input  logic [RA_W-1:0] id_rd_addr,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic [RA_W-1:0] exm_rd_addr,
    input  logic            exm_reg_write,
    input  logic            exm_mem_read,
    input  logic [XLEN-1:0] exm_result,
    input  logic [RA_W-1:0] mwb_rd_addr,
    input  logic            mwb_reg_write,
    input  logic [XLEN-1:0] mwb_result,
    input  logic            hold,
    input  logic            flush,
    output logic            id_stall,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [3:0]      alu_op,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [RA_W-1:0] ex_rd_addr,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc
);

    localparam logic [3:0] ALU_ADD = 4'd0;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [RA_W-1:0] rs1_addr_q, rs1_addr_d;
    logic [RA_W-1:0] rs2_addr_q, rs2_addr_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [3:0]      alu_op_q, alu_op_d;
    logic            src1_pc_q, src1_pc_d;
    logic            src2_imm_q, src2_imm_d;
    logic [RA_W-1:0] rd_addr_q, rd_addr_d;
    logic            reg_write_q, reg_write_d;
    logic            mem_read_q, mem_read_d;
    logic            mem_write_q, mem_write_d;

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            exm_hit1, exm_hit2, mwb_hit1, mwb_hit2;

    // A load in EX/MEM has no data yet; the interlock covers that case.
    assign exm_hit1 = exm_reg_write && !exm_mem_read && (exm_rd_addr != '0) && (exm_rd_addr == rs1_addr_q);
    assign exm_hit2 = exm_reg_write && !exm_mem_read && (exm_rd_addr != '0) && (exm_rd_addr == rs2_addr_q);
    assign mwb_hit1 = mwb_reg_write && (mwb_rd_addr != '0) && (mwb_rd_addr == rs1_addr_q);
    assign mwb_hit2 = mwb_reg_write && (mwb_rd_addr != '0) && (mwb_rd_addr == rs2_addr_q);

    assign fwd_rs1 = exm_hit1 ? exm_result : (mwb_hit1 ? mwb_result : rs1_data_q);
    assign fwd_rs2 = exm_hit2 ? exm_result : (mwb_hit2 ? mwb_result : rs2_data_q);

    assign id_stall = id_valid && valid_q && mem_read_q && (rd_addr_q != '0) &&
                      ((rd_addr_q == id_rs1_addr) || (rd_addr_q == id_rs2_addr));

    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        alu_op_d    = alu_op_q;
        src1_pc_d   = src1_pc_q;
        src2_imm_d  = src2_imm_q;
        rd_addr_d   = rd_addr_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        if (flush || (!hold && id_stall)) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else if (hold) begin
            // Keep operands alive while their producers retire past MEM/WB.
            rs1_data_d = fwd_rs1;
            rs2_data_d = fwd_rs2;
        end else begin
            valid_d     = id_valid;
            pc_d        = id_pc;
            rs1_addr_d  = id_rs1_addr;
            rs2_addr_d  = id_rs2_addr;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            imm_d       = id_imm;
            alu_op_d    = id_alu_op;
            src1_pc_d   = id_src1_pc;
            src2_imm_d  = id_src2_imm;
            rd_addr_d   = id_rd_addr;
            reg_write_d = id_valid && id_reg_write;
            mem_read_d  = id_valid && id_mem_read;
            mem_write_d = id_valid && id_mem_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            alu_op_q    <= ALU_ADD;
            src1_pc_q   <= 1'b0;
            src2_imm_q  <= 1'b0;
            rd_addr_q   <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            alu_op_q    <= alu_op_d;
            src1_pc_q   <= src1_pc_d;
            src2_imm_q  <= src2_imm_d;
            rd_addr_q   <= rd_addr_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign alu_in1       = src1_pc_q ? pc_q : fwd_rs1;
    assign alu_in2       = src2_imm_q ? imm_q : fwd_rs2;
    assign alu_op        = alu_op_q;
    assign ex_store_data = fwd_rs2;
    assign ex_valid      = valid_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_rd_addr    = rd_addr_q;
    assign ex_pc         = pc_q;

endmodule
